// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control sequencer for the SIP datapath
// Decodes accepted opcodes into ALU, mult/div handshake and branch control strobes.
module control_sequencer #(
    parameter int OPW      = 4,
    parameter int ALUCW    = 2,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [3:0]       flags,
    output logic             mc_start,
    input  logic             mc_done,
    output logic             regWrite,
    output logic             aluSrc,
    output logic             PCSrc,
    output logic             immSrc,
    output logic             flagUpdate,
    output logic [ALUCW-1:0] aluControl,
    output logic             busy,
    output logic             illegal,
    output logic             timeout
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_WB
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [OPW-1:0] op_q;
    logic [CW-1:0]  cnt;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           accept;

    logic           op_mul;
    logic           op_div;
    logic           op_add;
    logic           op_b;
    logic           op_beq;
    logic           op_bne;
    logic           op_illegal;
    logic           flag_z;
    logic           branch_taken;
    logic           cnt_last;
    logic [ALUCW-1:0] mc_alu;
    logic           unused_flags;

    assign accept = instr_valid && instr_ready;

    // ALU opcodes come in reg/imm pairs; the low bit selects the immediate operand.
    assign op_mul     = (op_q >> 1) == OPW'(0);
    assign op_div     = (op_q >> 1) == OPW'(1);
    assign op_add     = (op_q >> 1) == OPW'(2);
    assign op_b       = op_q == OPW'(6);
    assign op_beq     = op_q == OPW'(7);
    assign op_bne     = op_q == OPW'(8);
    assign op_illegal = op_q > OPW'(8);

    assign flag_z       = flags[2];
    assign unused_flags = ^{flags[3], flags[1:0]};
    assign branch_taken = op_b || (op_beq && flag_z) || (op_bne && !flag_z);
    assign mc_alu       = op_mul ? ALUCW'(1) : ALUCW'(2);
    assign cnt_last     = cnt == CW'(MAX_WAIT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= opcode;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Every output is forced low while rst_n is low, whatever state is held.
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        instr_ready = 1'b0;
        mc_start    = 1'b0;
        regWrite    = 1'b0;
        aluSrc      = 1'b0;
        PCSrc       = 1'b0;
        immSrc      = 1'b0;
        flagUpdate  = 1'b0;
        aluControl  = '0;
        busy        = 1'b0;
        illegal     = 1'b0;
        timeout     = 1'b0;

        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        state_nxt = S_EXEC;
                    end
                end

                S_EXEC: begin
                    busy      = 1'b1;
                    state_nxt = S_IDLE;
                    if (op_illegal) begin
                        illegal = 1'b1;
                    end else if (op_add) begin
                        aluSrc     = op_q[0];
                        regWrite   = 1'b1;
                        flagUpdate = 1'b1;
                    end else if (op_mul || op_div) begin
                        aluSrc     = op_q[0];
                        aluControl = mc_alu;
                        mc_start   = 1'b1;
                        cnt_clr    = 1'b1;
                        state_nxt  = S_WAIT;
                    end else begin
                        PCSrc = branch_taken;
                    end
                end

                S_WAIT: begin
                    busy       = 1'b1;
                    aluSrc     = op_q[0];
                    aluControl = mc_alu;
                    if (mc_done) begin
                        state_nxt = S_WB;
                    end else if (cnt_last) begin
                        timeout   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end

                S_WB: begin
                    busy       = 1'b1;
                    aluSrc     = op_q[0];
                    aluControl = mc_alu;
                    regWrite   = 1'b1;
                    flagUpdate = 1'b1;
                    state_nxt  = S_IDLE;
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
// Each instruction is expanded into its expected per-cycle output trace and compared in lockstep.
module tb_control_sequencer;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] flags;
    logic       mc_start;
    logic       mc_done;
    logic       regWrite;
    logic       aluSrc;
    logic       PCSrc;
    logic       immSrc;
    logic       flagUpdate;
    logic [1:0] aluControl;
    logic       busy;
    logic       illegal;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer #(
        .OPW      (4),
        .ALUCW    (2),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .flags       (flags),
        .mc_start    (mc_start),
        .mc_done     (mc_done),
        .regWrite    (regWrite),
        .aluSrc      (aluSrc),
        .PCSrc       (PCSrc),
        .immSrc      (immSrc),
        .flagUpdate  (flagUpdate),
        .aluControl  (aluControl),
        .busy        (busy),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (rdy busy st rw src pc imm fu alu2 ill to)", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {4'b0, instr_ready, busy, mc_start, regWrite, aluSrc, PCSrc, immSrc,
                flagUpdate, aluControl, illegal, timeout};
    endfunction

    function automatic logic [15:0] mk(input logic rdy, input logic bsy, input logic st,
                                       input logic rw, input logic src, input logic pc,
                                       input logic fu, input logic [1:0] alu,
                                       input logic ill, input logic to);
        return {4'b0, rdy, bsy, st, rw, src, pc, 1'b0, fu, alu, ill, to};
    endfunction

    function automatic logic [15:0] exp_exec(input int op, input logic [3:0] flg);
        logic pc;
        if (op > 8) return mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 1, 0);
        if (op >= 6) begin
            pc = (op == 6) || (op == 7 && flg[2]) || (op == 8 && !flg[2]);
            return mk(0, 1, 0, 0, 0, pc, 0, 2'd0, 0, 0);
        end
        if (op >= 4) return mk(0, 1, 0, 1, op[0], 0, 1, 2'd0, 0, 0);
        return mk(0, 1, 1, 0, op[0], 0, 0, (op < 2) ? 2'd1 : 2'd2, 0, 0);
    endfunction

    // Inputs are applied just after a rising edge; outputs are checked at the falling edge.
    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check(tag, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    // k = WAIT cycle in which mc_done arrives (0 = never).
    task automatic run_instr(input int op, input logic [3:0] flg, input int k);
        logic [1:0] alu;
        logic       src;
        logic       fin;
        instr_valid = 1'b1;
        opcode      = op[3:0];
        flags       = 4'($urandom);
        mc_done     = 1'($urandom);
        cyc("accept", mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        instr_valid = 1'b0;
        opcode      = 4'($urandom);
        flags       = flg;
        mc_done     = 1'($urandom);
        cyc("exec", exp_exec(op, flg));
        flags = 4'($urandom);
        if (op < 4) begin
            alu = (op < 2) ? 2'd1 : 2'd2;
            src = op[0];
            fin = 1'b0;
            for (int i = 1; i <= MAXW && !fin; i++) begin
                mc_done = (i == k);
                cyc("wait", mk(0, 1, 0, 0, src, 0, 0, alu, 0, (i == MAXW) && (k != MAXW)));
                if (i == k) begin
                    mc_done = 1'($urandom);
                    cyc("wb", mk(0, 1, 0, 1, src, 0, 1, alu, 0, 0));
                    fin = 1'b1;
                end
            end
        end
        mc_done = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        opcode      = 4'b0101;
        flags       = 4'b0000;
        mc_done     = 1'b1;
        #1;
        cyc("reset0", 16'h0);
        cyc("reset1", 16'h0);
        rst_n = 1'b1;

        run_instr(5, 4'b0000, 0);
        run_instr(0, 4'($urandom), 3);
        run_instr(7, 4'b0100, 0);
        run_instr(7, 4'b0000, 0);
        run_instr(8, 4'b0000, 0);
        run_instr(8, 4'b0100, 0);
        run_instr(6, 4'($urandom), 0);
        run_instr(3, 4'($urandom), 0);
        run_instr(3, 4'($urandom), MAXW);
        run_instr(1, 4'($urandom), 1);

        instr_valid = 1'b0;
        mc_done     = 1'b1;
        cyc("idle_stray0", mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        cyc("idle_stray1", mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        mc_done = 1'b0;
        run_instr(15, 4'($urandom), 0);

        instr_valid = 1'b1;
        opcode      = 4'b0010;
        cyc("rst_accept", mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        instr_valid = 1'b0;
        cyc("rst_exec", exp_exec(2, 4'b0000));
        cyc("rst_wait1", mk(0, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0));
        rst_n   = 1'b0;
        mc_done = 1'b1;
        cyc("rst_mid", 16'h0);
        rst_n   = 1'b1;
        mc_done = 1'b0;
        run_instr(2, 4'($urandom), 2);

        repeat (150) begin
            int gap;
            run_instr(int'($urandom_range(0, 15)), 4'($urandom), int'($urandom_range(0, MAXW)));
            gap = int'($urandom_range(0, 2));
            instr_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                mc_done = 1'($urandom);
                cyc("gap", mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
